serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/serial_rx.sv | 191 +++++++++++++++++++
 tb/tb_serial_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg -- shared types and constants for the serial receiver.
//   rx_state_t            : receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT  : clk_in cycles per bit at 100 MHz / 115200 baud
//   DATA_BITS             : payload bits per frame
// Optional feature macro: SERIAL_RX_PARITY_EN (adds the ST_PARITY state).
package serial_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for an asynchronous single-bit input.
//   clk_in   : destination clock
//   rst_in   : asynchronous active-high reset, both flops load RESET_VAL
//   async_in : asynchronous input
//   sync_out : synchronized output (two clk_in cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/serial_rx.sv
// serial_rx -- 8N1 serial receiver with mid-bit sampling and selectable bit order.
//   clk_in     : system clock, rising edge
//   rst_in     : asynchronous active-high reset
//   data_in    : asynchronous serial line, idles high
//   big_endian : 1 = first data bit lands in data_out[7], 0 = in data_out[0]
//   data_out   : last correctly framed byte
//   valid_out  : one-cycle pulse when data_out is updated
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   busy       : high whenever the FSM is not idle
//   parity_err : (SERIAL_RX_PARITY_EN only) one-cycle pulse on even-parity mismatch
// Optional feature macro: SERIAL_RX_PARITY_EN (even parity bit after the data bits).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for rx_s low
// ST_START  | timing to the middle of the start bit, reject glitches
// ST_DATA   | sampling the 8 data bits at mid-bit
// ST_PARITY | sampling the parity bit (parity build only)
// ST_STOP   | sampling the stop bit, then deliver byte or flag an error
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       data_in,
  input  logic       big_endian,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err,
  output logic       busy
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (data_in),
    .sync_out (rx_s)
  );

  rx_state_t     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          order_q, order_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      order_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      order_q   <= order_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    order_d   = order_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (count_q == HALF_M1) begin
          count_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            order_d   = big_endian;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (count_q == FULL_M1) begin
          count_d   = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          // LSB-first order shifts in from the top, MSB-first from the bottom,
          // so sample 0 finishes in bit 0 or bit 7 respectively.
          shift_d   = order_q ? {shift_q[6:0], rx_s} : {rx_s, shift_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (count_q == FULL_M1) begin
          count_d   = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = ST_STOP;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (count_q == FULL_M1) begin
          count_d = '0;
          state_d = ST_IDLE;
`ifdef SERIAL_RX_PARITY_EN
          if (par_bad_q) begin
            perr_d = 1'b1;
          end else
`endif
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;

  localparam int CPB = 16;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       data_in = 1'b1;
  logic       big_endian = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err;
  logic       busy;
`ifdef SERIAL_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .data_in    (data_in),
    .big_endian (big_endian),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef SERIAL_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int vcnt = 0, fcnt = 0, pcnt = 0, both_cnt = 0, busy_cyc = 0, valid_cyc = 0;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (valid_out) begin
      vcnt++;
      valid_cyc = cyc;
    end
    if (frame_err) fcnt++;
    if (valid_out && frame_err) both_cnt++;
    if (busy) busy_cyc++;
`ifdef SERIAL_RX_PARITY_EN
    if (parity_err) pcnt++;
    if (parity_err && (valid_out || frame_err)) both_cnt++;
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic clear_mon();
    vcnt = 0; fcnt = 0; pcnt = 0; busy_cyc = 0;
  endtask

  task automatic send_bit(input logic v);
    data_in = v;
    repeat (CPB) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    repeat (4) @(posedge clk_in);
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    n_cmp++;
    if (busy) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, k);
    end
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic toggle);
    @(posedge clk_in);
    #1;
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (toggle) big_endian = ~big_endian;
      send_bit(b[i]);
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_v);
    data_in = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h required 00", data_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", valid_out); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr: got %b required 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  task automatic test_lsb_first();
    int lat;
    clear_mon();
    big_endian = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    lat = valid_cyc - fall_cyc;
    n_cmp++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL lsb_data: got %h required a5", data_out); end
    n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL lsb_valid_cnt: got %0d required 1", vcnt); end
    n_cmp++; if (fcnt !== 0) begin n_fail++; $display("FAIL lsb_ferr_cnt: got %0d required 0", fcnt); end
    n_cmp++; if (lat < 153 || lat > 155) begin n_fail++; $display("FAIL latency: got %0d required 153..155", lat); end
  endtask

  task automatic test_big_endian();
    clear_mon();
    big_endian = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL be_a5: got %h required a5", data_out); end
    send_frame(8'h01, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 8'h80) begin n_fail++; $display("FAIL be_01: got %h required 80", data_out); end
    send_frame(8'h13, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 8'hC8) begin n_fail++; $display("FAIL be_13: got %h required c8", data_out); end
    n_cmp++; if (vcnt !== 3) begin n_fail++; $display("FAIL be_valid_cnt: got %0d required 3", vcnt); end
    big_endian = 1'b0;
  endtask

  task automatic test_glitch();
    clear_mon();
    @(posedge clk_in);
    #1;
    data_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    data_in = 1'b1;
    repeat (40) @(posedge clk_in);
    #1;
    n_cmp++; if (busy_cyc < 1 || busy_cyc > 10) begin n_fail++; $display("FAIL glitch_busy: got %0d cycles required 1..10", busy_cyc); end
    n_cmp++; if (vcnt !== 0 || fcnt !== 0) begin n_fail++; $display("FAIL glitch_pulses: got v=%0d f=%0d required 0/0", vcnt, fcnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy=%b required 0", busy); end
    n_cmp++; if (data_out !== 8'hC8) begin n_fail++; $display("FAIL glitch_data: got %h required c8", data_out); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    n_cmp++; if (fcnt !== 1) begin n_fail++; $display("FAIL ferr_cnt: got %0d required 1", fcnt); end
    n_cmp++; if (vcnt !== 0) begin n_fail++; $display("FAIL ferr_valid_cnt: got %0d required 0", vcnt); end
    n_cmp++; if (data_out !== 8'hC8) begin n_fail++; $display("FAIL ferr_data_kept: got %h required c8", data_out); end
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 8'h55) begin n_fail++; $display("FAIL after_ferr_data: got %h required 55", data_out); end
    n_cmp++; if (vcnt !== 1 || fcnt !== 0) begin n_fail++; $display("FAIL after_ferr_pulses: got v=%0d f=%0d required 1/0", vcnt, fcnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    @(posedge clk_in);
    #1;
    send_bit(1'b0);
    data_in = 1'b1;
    repeat (CPB * 4 + CPB / 2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (CPB * 5) @(posedge clk_in);
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h required 00", data_out); end
    n_cmp++; if (vcnt !== 0 || fcnt !== 0) begin n_fail++; $display("FAIL midrst_pulses: got v=%0d f=%0d required 0/0", vcnt, fcnt); end
    send_frame(8'h12, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 8'h12) begin n_fail++; $display("FAIL midrst_next: got %h required 12", data_out); end
    n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL midrst_next_valid: got %0d required 1", vcnt); end
  endtask

  task automatic test_order_latch();
    clear_mon();
    big_endian = 1'b0;
    send_frame(8'h0F, 1'b1, 1'b1);
    n_cmp++; if (data_out !== 8'h0F) begin n_fail++; $display("FAIL order_latch: got %h required 0f", data_out); end
    n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL order_latch_valid: got %0d required 1", vcnt); end
    big_endian = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    clear_mon();
    par_flip = 1'b1;
    send_frame(8'h3A, 1'b1, 1'b0);
    par_flip = 1'b0;
    n_cmp++; if (pcnt !== 1) begin n_fail++; $display("FAIL parity_cnt: got %0d required 1", pcnt); end
    n_cmp++; if (vcnt !== 0 || fcnt !== 0) begin n_fail++; $display("FAIL parity_others: got v=%0d f=%0d required 0/0", vcnt, fcnt); end
    n_cmp++; if (data_out !== 8'h0F) begin n_fail++; $display("FAIL parity_data_kept: got %h required 0f", data_out); end
`endif
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d required 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_big_endian();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_order_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
